// File: rtl/input_checker_if.sv
// input_checker_if: handshake/bus bundle between the sequence player side and the input checker
// start_input, difficulty_k, answer_seq, btn : driven by master, sampled by the checker
// input_cnt, result_valid, pass, fail, timeout, busy : driven by the checker
interface input_checker_if;
  logic        start_input;
  logic [3:0]  difficulty_k;
  logic [31:0] answer_seq;
  logic [7:0]  btn;
  logic [3:0]  input_cnt;
  logic        result_valid;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic        busy;
  modport master (
    output start_input, difficulty_k, answer_seq, btn,
    input  input_cnt, result_valid, pass, fail, timeout, busy
  );
  modport slave (
    input  start_input, difficulty_k, answer_seq, btn,
    output input_cnt, result_valid, pass, fail, timeout, busy
  );
endinterface

// File: rtl/input_checker.sv
// input_checker: checks a button press sequence against an expected answer with an idle timeout
// clk, rst_n (async active-low) : clock and reset
// bus.start_input/difficulty_k/answer_seq/btn : arm pulse, entry count, expected nibbles, buttons
// bus.input_cnt/result_valid/pass/fail/timeout/busy : progress, verdict pulse and verdict levels
module input_checker #(
  parameter logic [27:0] TIMEOUT_CYC = 28'd150000000
) (
  input logic clk,
  input logic rst_n,
  input_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, COLLECT, DONE} state_t;
  state_t state, state_d;
  logic [7:0] s1, s2, s3, rise, want;
  logic [31:0] seq_q, seq_d;
  logic [27:0] timer, timer_d;
  logic [3:0] keff_q, keff_d, cnt, cnt_d, expv;
  logic pass_q, pass_d, fail_q, fail_d, to_q, to_d, rv_q, rv_d;
  assign rise = s2 & ~s3;
  assign expv = seq_q[{cnt[2:0], 2'b00} +: 4];
  // out-of-range entries give an all-zero target that no press can equal;
  // multiple simultaneous edges can never equal a one-hot target either
  assign want = (expv != 4'd0 && expv <= 4'd8) ? 8'd1 << (expv - 4'd1) : 8'd0;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    pass_d = pass_q;
    fail_d = fail_q;
    to_d = to_q;
    rv_d = 1'b0;
    timer_d = timer;
    seq_d = seq_q;
    keff_d = keff_q;
    if (bus.start_input) begin
      state_d = ARMED;
      cnt_d = 4'd0;
      pass_d = 1'b0;
      fail_d = 1'b0;
      to_d = 1'b0;
      timer_d = 28'd0;
      seq_d = bus.answer_seq;
      keff_d = bus.difficulty_k == 4'd0 ? 4'd1 : bus.difficulty_k > 4'd8 ? 4'd8 : bus.difficulty_k;
    end else if (state == ARMED) begin
      state_d = s2 == 8'd0 ? COLLECT : ARMED;
    end else if (state == COLLECT) begin
      if (|rise && rise == want) begin
        cnt_d = cnt + 4'd1;
        timer_d = 28'd0;
        state_d = cnt + 4'd1 == keff_q ? DONE : COLLECT;
        pass_d = cnt + 4'd1 == keff_q;
        rv_d = cnt + 4'd1 == keff_q;
      end else if (|rise) begin
        state_d = DONE;
        fail_d = 1'b1;
        rv_d = 1'b1;
      end else if (timer == TIMEOUT_CYC - 28'd1) begin
        state_d = DONE;
        fail_d = 1'b1;
        to_d = 1'b1;
        rv_d = 1'b1;
      end else begin
        timer_d = timer + 28'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {s1, s2, s3} <= '0;
      seq_q <= '0;
      keff_q <= '0;
      timer <= '0;
      cnt <= '0;
      {pass_q, fail_q, to_q, rv_q} <= '0;
    end else begin
      state <= state_d;
      s1 <= bus.btn;
      s2 <= s1;
      s3 <= s2;
      seq_q <= seq_d;
      keff_q <= keff_d;
      timer <= timer_d;
      cnt <= cnt_d;
      {pass_q, fail_q, to_q, rv_q} <= {pass_d, fail_d, to_d, rv_d};
    end
  end
  assign bus.input_cnt = cnt;
  assign bus.result_valid = rv_q;
  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
  assign bus.timeout = to_q;
  assign bus.busy = state == ARMED || state == COLLECT;
endmodule

// File: tb/tb_input_checker.sv
// tb_input_checker: directed scoreboard bench for input_checker
module tb_input_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic p;
    logic f;
    logic t;
    logic [3:0] c;
    int at;
  } exp_t;
  exp_t q[$];
  input_checker_if bus();
  input_checker #(.TIMEOUT_CYC(28'd100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result at cyc=%0d got p=%b f=%b t=%b c=%0d want none", cyc, bus.pass, bus.fail, bus.timeout, bus.input_cnt);
      end else begin
        e = q.pop_front();
        if (bus.pass !== e.p || bus.fail !== e.f || bus.timeout !== e.t || bus.input_cnt !== e.c || (e.at >= 0 && cyc != e.at)) begin
          failures++;
          $display("FAIL result got p=%b f=%b t=%b c=%0d cyc=%0d want p=%b f=%b t=%b c=%0d cyc=%0d", bus.pass, bus.fail, bus.timeout, bus.input_cnt, cyc, e.p, e.f, e.t, e.c, e.at);
        end
      end
    end
  end
  task automatic push(input logic p, input logic f, input logic t, input logic [3:0] c, input int at);
    exp_t e;
    e.p = p;
    e.f = f;
    e.t = t;
    e.c = c;
    e.at = at;
    q.push_back(e);
  endtask
  task automatic start(input logic [3:0] k, input logic [31:0] s);
    @(negedge clk);
    bus.start_input = 1'b1;
    bus.difficulty_k = k;
    bus.answer_seq = s;
    @(negedge clk);
    bus.start_input = 1'b0;
    bus.difficulty_k = 4'hf;
    bus.answer_seq = 32'hffffffff;
    chk("start_clear", {bus.busy, bus.pass, bus.fail, bus.timeout, bus.input_cnt}, 8'b1000_0000);
    @(negedge clk);
  endtask
  task automatic press(input int i);
    bus.btn = 8'd1 << i;
    repeat (4) @(negedge clk);
    bus.btn = 8'd0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int c;
    bus.start_input = 1'b0;
    bus.difficulty_k = 4'd0;
    bus.answer_seq = 32'd0;
    bus.btn = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.busy, bus.result_valid, bus.pass, bus.fail, bus.timeout, bus.input_cnt}, 9'd0);
    rst_n = 1'b1;
    start(4'd3, 32'h352);
    push(1, 0, 0, 4'd3, -1);
    press(1);
    chk("pass_cnt1", bus.input_cnt, 4'd1);
    press(4);
    chk("pass_cnt2", bus.input_cnt, 4'd2);
    press(2);
    chk("pass_final", {bus.busy, bus.pass, bus.fail, bus.input_cnt}, 7'b0_1_0_0011);
    press(0);
    chk("done_ignores_btn", {bus.pass, bus.input_cnt}, 5'b1_0011);
    start(4'd3, 32'h352);
    push(0, 1, 0, 4'd1, -1);
    press(1);
    press(3);
    chk("mismatch", {bus.pass, bus.fail, bus.timeout, bus.input_cnt}, 7'b0_1_0_0001);
    start(4'd2, 32'h21);
    bus.btn = 8'd1;
    c = -1;
    for (int i = 0; i < 20 && c < 0; i++) begin
      @(negedge clk);
      if (bus.input_cnt == 4'd1) c = cyc;
    end
    chk("timeout_press_seen", c >= 0, 1'b1);
    push(0, 1, 1, 4'd1, c + 100);
    bus.btn = 8'd0;
    repeat (110) @(negedge clk);
    chk("timeout_levels", {bus.busy, bus.pass, bus.fail, bus.timeout}, 4'b0011);
    bus.btn = 8'd1;
    repeat (4) @(negedge clk);
    start(4'd1, 32'h1);
    repeat (5) @(negedge clk);
    chk("held_not_counted", {bus.busy, bus.input_cnt, bus.result_valid}, 6'b1_0000_0);
    bus.btn = 8'd0;
    repeat (4) @(negedge clk);
    c = cyc;
    push(1, 0, 0, 4'd1, c + 3);
    press(0);
    start(4'd2, 32'h52);
    push(0, 1, 0, 4'd0, -1);
    bus.btn = 8'h12;
    repeat (4) @(negedge clk);
    bus.btn = 8'd0;
    repeat (4) @(negedge clk);
    chk("double_edge", {bus.pass, bus.fail}, 2'b01);
    start(4'd0, 32'h7);
    push(1, 0, 0, 4'd1, -1);
    press(6);
    chk("k0_pass", {bus.pass, bus.input_cnt}, 5'b1_0001);
    start(4'd3, 32'h352);
    press(1);
    chk("pre_reset_cnt", bus.input_cnt, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.busy, bus.result_valid, bus.pass, bus.fail, bus.timeout, bus.input_cnt}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    press(1);
    press(4);
    press(2);
    chk("idle_after_reset", {bus.busy, bus.pass, bus.fail, bus.input_cnt}, 7'd0);
    start(4'd1, 32'h2);
    push(1, 0, 0, 4'd1, -1);
    press(1);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=expired want=finish");
    $fatal(1, "watchdog");
  end
endmodule
